arb_rr_enc: RTL and testbench
=============================

ARB_RR_ENC -- requirements
Module: arb_rr_enc

Interface
REQ-001 SHALL have parameter W, default 4, number of requestors; legal range 2..64, non-power-of-2 allowed.
REQ-002 SHALL have parameter IDX_W, default $clog2(W), width of encoded grant index.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  W  per-requestor request, bit i = requestor i.
REQ-006 SHALL have port gnt_vld_o  output  1  encoded grant valid.
REQ-007 SHALL have port gnt_idx_o  output  IDX_W  encoded index of granted requestor.
REQ-008 SHALL have port gnt_rdy_i  input  1  downstream accepts grant; transfer when gnt_vld_o and gnt_rdy_i both high.

Function
REQ-009 SHALL implement two states: IDLE (no grant held) and HOLD (grant presented, awaiting accept).
REQ-010 SHALL, in IDLE with req_i != 0, select the first set bit of req_i at or above pointer ptr, wrapping W-1 -> 0, register it to gnt_idx_o, assert gnt_vld_o and enter HOLD next cycle (latency 1 cycle req -> grant).
REQ-011 SHALL remain in IDLE with gnt_vld_o low when req_i == 0.
REQ-012 SHALL, in HOLD, keep gnt_vld_o high and gnt_idx_o stable every cycle until accept, regardless of req_i changes.
REQ-013 SHALL, on accept, update ptr to gnt_idx_o + 1, wrapping to 0 when gnt_idx_o == W-1 (not at 2^IDX_W).
REQ-014 SHALL, on accept, re-arbitrate in the same cycle using req_i masked by the one-hot of the accepted index and the updated ptr; nonzero result -> stay HOLD with new index next cycle (back-to-back, one grant per cycle), zero -> IDLE with gnt_vld_o low.
REQ-015 SHALL never grant an index >= W; gnt_idx_o bits above a valid index are zero.
REQ-016 SHALL guarantee fairness: with all W bits continuously requested, each index is granted exactly once per W accepts.
REQ-017 SHALL hold ptr unchanged when no accept occurs.
REQ-018 SHALL treat requestors as responsible for keeping req_i asserted until their grant is accepted; a dropped request never retracts a presented grant.

Reset
REQ-019 SHALL, with rst high at a clock edge, force state IDLE, gnt_vld_o = 0, gnt_idx_o = 0, ptr = 0 on that edge, overriding any accept or request in the same cycle.
REQ-020 SHALL, on reset asserted mid-HOLD, drop the pending grant without it counting as accepted.
REQ-021 SHALL ignore req_i while rst is high; first grant appears no earlier than one cycle after rst deasserts.

Structure
REQ-022 SHALL place the state enum typedef (IDLE, HOLD) in shared package arb_rr_enc_pkg.
REQ-023 SHALL instantiate the team's existing binary-to-one-hot decoder module dec (W = W) to form the accepted-index mask for REQ-014.
REQ-024 SHALL implement the wrap-around priority pick as a combinational function inside arb_rr_enc; no other sub-modules.
REQ-025 SHALL be verified only for W >= 2; W = 1 is a compile-time error.

Verification
REQ-026 SHALL cover: W=4, rst 1 cycle, req_i=4'b0000 held 5 cycles -> gnt_vld_o stays 0, gnt_idx_o = 0.
REQ-027 SHALL cover: W=4, req_i=4'b1111 constant, gnt_rdy_i=1 -> gnt_idx_o sequence 0,1,2,3,0 on consecutive cycles, gnt_vld_o continuously high.
REQ-028 SHALL cover: W=4, req_i=4'b0100, gnt_rdy_i=0 for 3 cycles then 1 -> gnt_idx_o = 2 held for 4 cycles, then gnt_vld_o = 0, ptr = 3.
REQ-029 SHALL cover: W=5, ptr at 4, req_i=5'b00011 -> grant index 0 (wrap at W-1, not at 7), next accept grants 1.
REQ-030 SHALL cover: W=4, grant index 1 presented, rst asserted for 1 cycle with gnt_rdy_i=1 -> gnt_vld_o = 0, ptr = 0; with req_i=4'b0010 afterwards -> index 1 granted again one cycle after rst deasserts.
REQ-031 SHALL cover: W=4, req_i changes from 4'b1000 to 4'b0001 during HOLD on index 3 -> gnt_idx_o remains 3 until accept, then 0.

Source files
------------

// File: rtl/arb_rr_enc_pkg.sv
// Shared types for the round-robin encoded-grant arbiter.
package arb_rr_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_rr_enc_if.sv
// Request/grant bundle between requestors, the arbiter and the grant consumer.
// Handshake: the arbiter raises gnt_vld_o with gnt_idx_o and holds both stable until the
// consumer samples gnt_rdy_i high on a rising edge; that edge is the one and only transfer.
interface arb_rr_enc_if #(
    parameter int W     = 4,
    parameter int IDX_W = $clog2(W)
);
    logic [W-1:0]     req_i;
    logic             gnt_vld_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic             gnt_rdy_i;

    modport master (
        input  req_i,
        input  gnt_rdy_i,
        output gnt_vld_o,
        output gnt_idx_o
    );

    modport slave (
        output req_i,
        output gnt_rdy_i,
        input  gnt_vld_o,
        input  gnt_idx_o
    );
endinterface

// File: rtl/arb_rr_enc_dec.sv
// Binary-to-one-hot decoder; all outputs low when en is low.
module dec #(
    parameter int W     = 4,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [W-1:0]     onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < W; i++) begin
            if (en && (idx == IDX_W'(i))) onehot[i] = 1'b1;
        end
    end
endmodule

// File: rtl/arb_rr_enc.sv
// Round-robin arbiter presenting one encoded grant at a time, held until accepted.
// Accepting a grant re-arbitrates in the same cycle, so a busy bus gets one grant per cycle.
module arb_rr_enc
    import arb_rr_enc_pkg::*;
#(
    parameter int W     = 4,
    parameter int IDX_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    arb_rr_enc_if.master     bus,
    output arb_state_e       dbg_state,
    output logic [IDX_W-1:0] dbg_ptr
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(W - 1);

    if (W < 2) begin : g_bad_w
        $error("arb_rr_enc: W must be at least 2");
    end

    // Returns {found, idx}: the lowest set bit at or above ptr, else the lowest set bit overall.
    function automatic logic [IDX_W:0] pick(input logic [W-1:0] req, input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) >= ptr)) idx = IDX_W'(i);
        end
        return {found, idx};
    endfunction

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             accept;
    logic [W-1:0]     acc_mask;
    logic [W-1:0]     req_eff;
    logic [IDX_W:0]   pick_res;

    assign accept = (state_q == HOLD) && bus.gnt_rdy_i;

    dec #(.W(W), .IDX_W(IDX_W)) u_dec (
        .idx    (idx_q),
        .en     (accept),
        .onehot (acc_mask)
    );

    // Pointer wraps at W-1, not at the power of two above it.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Without an accept the mask is zero and ptr_d equals ptr_q, so one pick serves both states.
    assign req_eff  = bus.req_i & ~acc_mask;
    assign pick_res = pick(req_eff, ptr_d);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_res[IDX_W]) begin
                    state_d = HOLD;
                    idx_d   = pick_res[IDX_W-1:0];
                end
            end
            HOLD: begin
                if (accept) begin
                    if (pick_res[IDX_W]) idx_d = pick_res[IDX_W-1:0];
                    else                 state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt_vld_o = (state_q == HOLD);
    assign bus.gnt_idx_o = idx_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;
endmodule

// File: tb/tb_arb_rr_enc.sv
// Bench for arb_rr_enc: a W=4 and a W=5 instance checked against a round-robin reference model.
module tb_arb_rr_enc;
  import arb_rr_enc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst5;
  arb_state_e st4, st5;
  logic [1:0] ptr4;
  logic [2:0] ptr5;

  arb_rr_enc_if #(.W(4)) bus4 ();
  arb_rr_enc_if #(.W(5)) bus5 ();

  arb_rr_enc #(.W(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.master), .dbg_state(st4), .dbg_ptr(ptr4));
  arb_rr_enc #(.W(5)) dut5 (.clk(clk), .rst(rst5), .bus(bus5.master), .dbg_state(st5), .dbg_ptr(ptr5));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int         m_w[2] = '{4, 5};
  bit         m_hold[2];
  int         m_idx[2];
  int         m_ptr[2];
  logic [7:0] c_req[2];
  bit         c_rdy[2];
  bit         c_rst[2];

  // Next visible state from the rules: accept advances the pointer past the winner and
  // drops the winner's request; an idle arbiter scans circularly from the pointer.
  task automatic model_update(input int d);
    int w;
    logic [7:0] r;
    w = m_w[d];
    r = c_req[d];
    if (c_rst[d]) begin
      m_hold[d] = 0;
      m_idx[d]  = 0;
      m_ptr[d]  = 0;
      return;
    end
    if (m_hold[d] && c_rdy[d]) begin
      m_ptr[d]     = (m_idx[d] + 1) % w;
      r[m_idx[d]]  = 1'b0;
      m_hold[d]    = 0;
    end
    if (!m_hold[d]) begin
      for (int k = 0; k < w; k++) begin
        int c;
        c = (m_ptr[d] + k) % w;
        if (r[c]) begin
          m_hold[d] = 1;
          m_idx[d]  = c;
          break;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set(input int d, input logic [7:0] req, input bit rdy, input bit rst);
    c_req[d] = req;
    c_rdy[d] = rdy;
    c_rst[d] = rst;
  endtask

  task automatic step();
    bus4.req_i     = c_req[0][3:0];
    bus4.gnt_rdy_i = c_rdy[0];
    rst4           = c_rst[0];
    bus5.req_i     = c_req[1][4:0];
    bus5.gnt_rdy_i = c_rdy[1];
    rst5           = c_rst[1];
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int d);
    set(d, 8'h00, 1'b0, 1'b1);
    step();
    set(d, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic obs_vld(input int d);
    return (d == 0) ? bus4.gnt_vld_o : bus5.gnt_vld_o;
  endfunction

  function automatic logic [7:0] obs_idx(input int d);
    return (d == 0) ? {6'b0, bus4.gnt_idx_o} : {5'b0, bus5.gnt_idx_o};
  endfunction

  function automatic logic [7:0] obs_ptr(input int d);
    return (d == 0) ? {6'b0, ptr4} : {5'b0, ptr5};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    set(0, 8'h0f, 1'b1, 1'b1);
    set(1, 8'h1f, 1'b1, 1'b1);
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs_vld(d) !== 1'b0 || obs_idx(d) !== 8'd0 || obs_ptr(d) !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_state d%0d: vld=%b idx=%0d ptr=%0d, want 0/0/0", d, obs_vld(d), obs_idx(d), obs_ptr(d));
      end
    end
    set(0, 8'h00, 1'b0, 1'b0);
    set(1, 8'h00, 1'b0, 1'b0);
    reset_dut(0);
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if (obs_vld(0) !== 1'b0 || obs_idx(0) !== 8'd0) begin
        n_fail++;
        $display("FAIL idle_no_req cyc%0d: vld=%b idx=%0d, want 0/0", c, obs_vld(0), obs_idx(0));
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    reset_dut(0);
    set(0, 8'h0f, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if (obs_vld(0) !== 1'b1 || obs_idx(0) !== 8'(exp_seq[c])) begin
        n_fail++;
        $display("FAIL round_robin cyc%0d: vld=%b idx=%0d, want 1/%0d", c, obs_vld(0), obs_idx(0), exp_seq[c]);
      end
    end
  endtask

  task automatic test_hold_stall();
    reset_dut(0);
    set(0, 8'h04, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (obs_vld(0) !== 1'b1 || obs_idx(0) !== 8'd2) begin
        n_fail++;
        $display("FAIL hold_stall cyc%0d: vld=%b idx=%0d, want 1/2", c, obs_vld(0), obs_idx(0));
      end
    end
    set(0, 8'h04, 1'b1, 1'b0);
    step();
    n_tests++;
    if (obs_vld(0) !== 1'b0 || obs_ptr(0) !== 8'd3) begin
      n_fail++;
      $display("FAIL hold_accept: vld=%b ptr=%0d, want 0/3", obs_vld(0), obs_ptr(0));
    end
    set(0, 8'h00, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_wrap_w5();
    reset_dut(1);
    set(1, 8'h08, 1'b1, 1'b0);
    step();
    n_tests++;
    if (obs_vld(1) !== 1'b1 || obs_idx(1) !== 8'd3) begin
      n_fail++;
      $display("FAIL wrap5_first: vld=%b idx=%0d, want 1/3", obs_vld(1), obs_idx(1));
    end
    set(1, 8'h03, 1'b1, 1'b0);
    step();
    n_tests++;
    if (obs_vld(1) !== 1'b1 || obs_idx(1) !== 8'd0 || obs_ptr(1) !== 8'd4) begin
      n_fail++;
      $display("FAIL wrap5_wrap: vld=%b idx=%0d ptr=%0d, want 1/0/4", obs_vld(1), obs_idx(1), obs_ptr(1));
    end
    step();
    n_tests++;
    if (obs_vld(1) !== 1'b1 || obs_idx(1) !== 8'd1 || obs_ptr(1) !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap5_next: vld=%b idx=%0d ptr=%0d, want 1/1/1", obs_vld(1), obs_idx(1), obs_ptr(1));
    end
    set(1, 8'h00, 1'b1, 1'b0);
    step();
    n_tests++;
    if (obs_vld(1) !== 1'b0 || obs_ptr(1) !== 8'd2) begin
      n_fail++;
      $display("FAIL wrap5_drain: vld=%b ptr=%0d, want 0/2", obs_vld(1), obs_ptr(1));
    end
  endtask

  task automatic test_reset_mid_hold();
    reset_dut(0);
    set(0, 8'h02, 1'b0, 1'b0);
    step();
    n_tests++;
    if (obs_vld(0) !== 1'b1 || obs_idx(0) !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_hold_pre: vld=%b idx=%0d, want 1/1", obs_vld(0), obs_idx(0));
    end
    set(0, 8'h02, 1'b1, 1'b1);
    step();
    n_tests++;
    if (obs_vld(0) !== 1'b0 || obs_ptr(0) !== 8'd0 || obs_idx(0) !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_hold_drop: vld=%b idx=%0d ptr=%0d, want 0/0/0", obs_vld(0), obs_idx(0), obs_ptr(0));
    end
    set(0, 8'h02, 1'b0, 1'b0);
    step();
    n_tests++;
    if (obs_vld(0) !== 1'b1 || obs_idx(0) !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_hold_regrant: vld=%b idx=%0d, want 1/1", obs_vld(0), obs_idx(0));
    end
    set(0, 8'h00, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_req_change();
    reset_dut(0);
    set(0, 8'h08, 1'b0, 1'b0);
    step();
    set(0, 8'h01, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (obs_vld(0) !== 1'b1 || obs_idx(0) !== 8'd3) begin
        n_fail++;
        $display("FAIL req_change_hold cyc%0d: vld=%b idx=%0d, want 1/3", c, obs_vld(0), obs_idx(0));
      end
    end
    set(0, 8'h01, 1'b1, 1'b0);
    step();
    n_tests++;
    if (obs_vld(0) !== 1'b1 || obs_idx(0) !== 8'd0 || obs_ptr(0) !== 8'd0) begin
      n_fail++;
      $display("FAIL req_change_next: vld=%b idx=%0d ptr=%0d, want 1/0/0", obs_vld(0), obs_idx(0), obs_ptr(0));
    end
    set(0, 8'h00, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_fairness_w5();
    int cnt[5] = '{0, 0, 0, 0, 0};
    reset_dut(1);
    set(1, 8'h1f, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (obs_vld(1) === 1'b1 && obs_idx(1) < 8'd5) cnt[obs_idx(1)]++;
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (cnt[i] != 2) begin
        n_fail++;
        $display("FAIL fairness5 idx%0d: granted %0d times, want 2", i, cnt[i]);
      end
    end
    set(1, 8'h00, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_random();
    reset_dut(0);
    reset_dut(1);
    for (int c = 0; c < 400; c++) begin
      set(0, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
      set(1, 8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_vld(d) !== 1'(m_hold[d]) || obs_ptr(d) !== 8'(m_ptr[d])) begin
          n_fail++;
          $display("FAIL random d%0d cyc%0d: vld=%b ptr=%0d, want %0d/%0d", d, c, obs_vld(d), obs_ptr(d), m_hold[d], m_ptr[d]);
        end
        if (m_hold[d]) begin
          n_tests++;
          if (obs_idx(d) !== 8'(m_idx[d]) || obs_idx(d) >= 8'(m_w[d])) begin
            n_fail++;
            $display("FAIL random_idx d%0d cyc%0d: idx=%0d, want %0d", d, c, obs_idx(d), m_idx[d]);
          end
        end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      m_hold[d] = 0;
      m_idx[d]  = 0;
      m_ptr[d]  = 0;
      set(d, 8'h00, 1'b0, 1'b1);
    end
    test_reset();
    test_round_robin();
    test_hold_stall();
    test_wrap_w5();
    test_reset_mid_hold();
    test_req_change();
    test_fairness_w5();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
